bit_serial_adder: RTL and testbench
===================================

BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 SHALL have parameter N, default 8, giving the operand width in bits; legal range 2..64.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, the asynchronous active-low reset.
REQ-004 SHALL have port i_valid, input, 1 bit, meaning an operand set is offered.
REQ-005 SHALL have port i_ready, output, 1 bit, meaning the block can accept operands.
REQ-006 SHALL have port a, input, N bits, operand A.
REQ-007 SHALL have port b, input, N bits, operand B.
REQ-008 SHALL have port c_in, input, 1 bit, the carry-in for the addition.
REQ-009 SHALL have port o_valid, output, 1 bit, meaning the result is presented.
REQ-010 SHALL have port o_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-011 SHALL have port sum, output, N bits, the result (a+b+c_in) mod 2^N.
REQ-012 SHALL have port c_out, output, 1 bit, the carry out of bit N-1.
REQ-013 SHALL have port overflow, output, 1 bit, the two's-complement signed overflow flag.

Function
REQ-014 SHALL compute the sum with exactly one combinational 1-bit full-adder cell, reused one bit per cycle, LSB first.
- The full-adder cell has inputs a, b, c_in and outputs sum, c_out.
REQ-015 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-016 SHALL drive i_ready=1 only in IDLE and o_valid=1 only in DONE.
REQ-017 SHALL accept operands in IDLE when i_valid=1, which is an input handshake.
- On that edge: latch a, b and c_in into shift/carry registers, clear the bit counter, go to RUN.
REQ-018 SHALL process one bit per RUN cycle.
- Shift the adder's sum bit into result register bit N-1, with the result register shifting right.
- Shift the operand registers right.
- Register the adder's carry.
- Increment the bit counter.
REQ-019 SHALL leave RUN for DONE on the edge that processes bit N-1.
- Input handshake to o_valid rising is exactly N+1 clock edges.
REQ-020 SHALL compute overflow as the carry into bit N-1 XOR the carry out of bit N-1, captured when bit N-1 is processed.
REQ-021 SHALL hold sum, c_out and overflow stable while o_valid=1 and o_ready=0, for any number of cycles.
REQ-022 SHALL return from DONE to IDLE when o_ready=1, which is an output handshake; i_ready rises on the following cycle.
- No same-cycle accept of a new operand in DONE.
REQ-023 SHALL ignore i_valid, a, b and c_in outside IDLE.
- Operand changes during RUN or DONE SHALL NOT affect the result in flight.
REQ-024 SHALL keep the sum, c_out and overflow registers of the last completed operation unchanged in IDLE, until the next accept.
REQ-025 SHALL size the bit counter to $clog2(N) bits, and the counter SHALL NOT wrap during a run.

Reset
REQ-026 SHALL, on rst=0 asynchronously and regardless of clk, force the following:
- State = IDLE.
- i_ready=1, o_valid=0.
- sum=0, c_out=0, overflow=0.
- Bit counter = 0 and carry register = 0.
REQ-027 SHALL abandon any operation in progress on a reset asserted during RUN or DONE, with no partial result ever presented.
REQ-028 SHALL accept an operand on the first rising edge with rst=1 and i_valid=1.

Verification
REQ-029 SHALL pass basic add and latency:
- Stimulus: N=8, a=0x35, b=0x1A, c_in=0, o_ready=1.
- Response: sum=0x4F, c_out=0, overflow=0; o_valid high exactly 9 edges after the accept, for 1 cycle.
REQ-030 SHALL pass carry and wrap:
- Stimulus: a=0xFF, b=0x01, c_in=0.
- Response: sum=0x00, c_out=1, overflow=0.
- Stimulus: a=0xFF, b=0xFF, c_in=1.
- Response: sum=0xFF, c_out=1, overflow=0.
REQ-031 SHALL pass signed overflow:
- Stimulus: a=0x7F, b=0x01.
- Response: sum=0x80, overflow=1, c_out=0.
- Stimulus: a=0x80, b=0x80.
- Response: sum=0x00, overflow=1, c_out=1.
REQ-032 SHALL pass backpressure:
- Stimulus: hold o_ready=0 for 5 cycles after o_valid rises, and toggle a, b and i_valid meanwhile.
- Response: result stable, i_ready=0 throughout; IDLE one cycle after o_ready=1.
REQ-033 SHALL pass reset mid-operation:
- Stimulus: assert rst=0 between edges at bit 3 of a run.
- Response: i_ready=1, o_valid=0 and sum=0 immediately; a fresh a=0x01, b=0x02 then yields sum=0x03.
REQ-034 SHALL pass a randomized sweep:
- Stimulus: 1000 random a, b, c_in with random o_ready stalls, at N=8 and N=32.
- Response: every result matches a+b+c_in, with correct c_out and overflow.

Source files
------------

// File: rtl/bit_serial_adder.sv
// -----------------------------------------------------------------------------
// bit_serial_adder
//
// Adds two N-bit operands plus a carry-in using a single 1-bit full-adder
// cell. The cell is reused once per clock, LSB first, so a result takes N
// cycles of RUN after the operands are accepted.
//
// Ports
//   clk        : clock; all state changes on its rising edge
//   rst        : asynchronous active-low reset
//   i_valid    : operand set offered (a, b, c_in)
//   i_ready    : block can accept operands (high only in IDLE)
//   a, b       : N-bit operands
//   c_in       : carry-in
//   o_valid    : result presented (high only in DONE)
//   o_ready    : consumer accepts the result
//   sum        : (a + b + c_in) mod 2^N
//   c_out      : carry out of bit N-1
//   overflow   : two's-complement signed overflow
//   dbg_state  : current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer side (i_valid/a/b/c_in) is only looked at while
// i_ready is high; once o_valid is high, sum/c_out/overflow are held until the
// edge where o_ready is also high. Neither ready depends combinationally on
// the corresponding valid.
// -----------------------------------------------------------------------------

// One-bit full-adder cell; the only arithmetic element of the adder.
module bit_serial_adder_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module bit_serial_adder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         overflow,
    output logic [1:0]   dbg_state
);
    localparam int            CW       = $clog2(N);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  res_q, res_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fa_s;
    logic          fa_c;

    bit_serial_adder_fa u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Sum bits enter at the MSB and walk down, so after N shifts
                // bit 0 of the result sits in res_q[0].
                res_d   = {fa_s, res_q[N-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_c;
                if (cnt_q == LAST_BIT) begin
                    // carry_q is the carry into the sign bit here.
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    state_d = DONE;
                end else begin
                    // Counter stops at N-1 so it never wraps for power-of-2 N.
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (o_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign i_ready   = (state_q == IDLE);
    assign o_valid   = (state_q == DONE);
    assign sum       = res_q;
    assign c_out     = cout_q;
    assign overflow  = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_adder
//
// Drives an N=8 and an N=32 instance of bit_serial_adder from shared stimulus.
// The 8-bit instance sees the low byte of the operands. Results are compared
// against an arithmetic reference model through per-instance expected queues.
// -----------------------------------------------------------------------------
module tb_bit_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic        c_in;
    logic [31:0] a;
    logic [31:0] b;

    logic        i_ready8, o_valid8, c_out8, overflow8;
    logic [7:0]  sum8;
    logic [1:0]  st8;
    logic        i_ready32, o_valid32, c_out32, overflow32;
    logic [31:0] sum32;
    logic [1:0]  st32;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [9:0]  exp8_q[$];
    logic [33:0] exp32_q[$];

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vecs[9];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    bit_serial_adder #(.N(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_ready   (i_ready8),
        .a         (a[7:0]),
        .b         (b[7:0]),
        .c_in      (c_in),
        .o_valid   (o_valid8),
        .o_ready   (o_ready),
        .sum       (sum8),
        .c_out     (c_out8),
        .overflow  (overflow8),
        .dbg_state (st8)
    );

    bit_serial_adder #(.N(32)) dut32 (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_ready   (i_ready32),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .o_valid   (o_valid32),
        .o_ready   (o_ready),
        .sum       (sum32),
        .c_out     (c_out32),
        .overflow  (overflow32),
        .dbg_state (st32)
    );

    // ---------------- reference model ----------------
    // Returns {overflow, c_out, sum} for an n-bit add.
    function automatic logic [65:0] ref_add(input int n, input logic [63:0] x,
                                            input logic [63:0] y, input logic ci);
        logic [64:0] full;
        logic [63:0] mask;
        logic [63:0] s;
        logic        co;
        logic        ov;
        mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        full = {1'b0, x & mask} + {1'b0, y & mask} + {64'd0, ci};
        s    = full[63:0] & mask;
        co   = full[n];
        // Signed overflow: operands share a sign that the result does not.
        ov   = (x[n-1] == y[n-1]) && (s[n-1] != x[n-1]);
        return {ov, co, s};
    endfunction

    // ---------------- scoreboard compare ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_iready8"}, i_ready8, 1);
        check({tag, "_ovalid8"}, o_valid8, 0);
        check({tag, "_sum8"}, sum8, 0);
        check({tag, "_cout8"}, c_out8, 0);
        check({tag, "_ovf8"}, overflow8, 0);
        check({tag, "_state8"}, st8, 0);
        check({tag, "_iready32"}, i_ready32, 1);
        check({tag, "_ovalid32"}, o_valid32, 0);
        check({tag, "_sum32"}, sum32, 0);
        check({tag, "_cout32"}, c_out32, 0);
        check({tag, "_ovf32"}, overflow32, 0);
        check({tag, "_state32"}, st32, 0);
    endtask

    // ---------------- driver: one transaction on both instances ----------------
    // Called and returns at a negative clock edge. max_stall=0 keeps o_ready
    // high; otherwise o_ready is high with probability 1/(max_stall+1).
    task automatic run_txn(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                           input int max_stall, output logic [9:0] r8);
        int          guard;
        int          edges;
        bit          seen8, seen32, done8, done32, pend8, pend32;
        logic [65:0] ref8;
        logic [65:0] ref32;
        logic [9:0]  last8;
        logic [33:0] last32;
        guard  = 0;
        r8     = '0;
        last8  = '0;
        last32 = '0;
        seen8  = 0; seen32 = 0; done8 = 0; done32 = 0; pend8 = 0; pend32 = 0;

        while (!(i_ready8 && i_ready32) && guard < 100) begin
            @(posedge clk); @(negedge clk); guard++;
        end
        check("accept_ready", {i_ready8, i_ready32}, 2'b11);

        ref8  = ref_add(8, {56'd0, av[7:0]}, {56'd0, bv[7:0]}, ci);
        ref32 = ref_add(32, {32'd0, av}, {32'd0, bv}, ci);
        exp8_q.push_back({ref8[65], ref8[64], ref8[7:0]});
        exp32_q.push_back({ref32[65], ref32[64], ref32[31:0]});

        a = av; b = bv; c_in = ci; i_valid = 1'b1; o_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        i_valid = 1'b0;
        a = $urandom; b = $urandom; c_in = 1'($urandom_range(0, 1));
        edges = 1;   // edges seen so far, counting the accept edge

        while ((!(done8 && done32) || pend8 || pend32) && edges < 400) begin
            if (pend8) begin
                check("idle8_iready", i_ready8, 1);
                check("idle8_ovalid", o_valid8, 0);
                check("idle8_hold", {overflow8, c_out8, sum8}, last8);
                pend8 = 0;
            end
            if (pend32) begin
                check("idle32_iready", i_ready32, 1);
                check("idle32_ovalid", o_valid32, 0);
                check("idle32_hold", {overflow32, c_out32, sum32}, last32);
                pend32 = 0;
            end
            if (!done8 && o_valid8) begin
                if (!seen8) begin
                    seen8 = 1;
                    check("latency8", edges, 9);
                end
                check("res8", {overflow8, c_out8, sum8}, exp8_q[0]);
                check("busy8_iready", i_ready8, 0);
            end
            if (!done32 && o_valid32) begin
                if (!seen32) begin
                    seen32 = 1;
                    check("latency32", edges, 33);
                end
                check("res32", {overflow32, c_out32, sum32}, exp32_q[0]);
                check("busy32_iready", i_ready32, 0);
            end

            o_ready = (max_stall == 0) ? 1'b1 : ($urandom_range(0, max_stall) == 0);

            if (!done8 && o_valid8 && o_ready) begin
                last8 = exp8_q.pop_front();
                r8    = {overflow8, c_out8, sum8};
                done8 = 1; pend8 = 1;
            end
            if (!done32 && o_valid32 && o_ready) begin
                last32 = exp32_q.pop_front();
                done32 = 1; pend32 = 1;
            end

            a = $urandom; b = $urandom;
            @(posedge clk); @(negedge clk);
            edges++;
        end
        check("drain8", done8, 1);
        check("drain32", done32, 1);
        o_ready = 1'b0;
    endtask

    // ---------------- hand sequence: backpressure ----------------
    task automatic bp_test();
        int guard;
        guard   = 0;
        o_ready = 1'b0;
        a = 32'h0000_0012; b = 32'h0000_0034; c_in = 1'b1; i_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        i_valid = 1'b0;
        while (!o_valid8 && guard < 50) begin
            @(posedge clk); @(negedge clk); guard++;
        end
        check("bp_reach_done", o_valid8, 1);
        for (int k = 0; k < 6; k++) begin
            check("bp_sum", sum8, 8'h47);
            check("bp_cout", c_out8, 0);
            check("bp_ovf", overflow8, 0);
            check("bp_iready", i_ready8, 0);
            check("bp_ovalid", o_valid8, 1);
            if (k < 5) begin
                a = $urandom; b = $urandom; c_in = 1'($urandom_range(0, 1));
                i_valid = ~i_valid;
                @(posedge clk); @(negedge clk);
            end
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("bp_idle_iready", i_ready8, 1);
        check("bp_idle_ovalid", o_valid8, 0);
        check("bp_idle_state", st8, 0);
        check("bp_idle_sum", sum8, 8'h47);
        // The 32-bit instance was in RUN during the toggling.
        guard = 0;
        while (!o_valid32 && guard < 60) begin
            @(posedge clk); @(negedge clk); guard++;
        end
        check("bp32_reach_done", o_valid32, 1);
        check("bp32_res", {overflow32, c_out32, sum32}, {2'b00, 32'h0000_0047});
        @(posedge clk); @(negedge clk);
        check("bp32_idle", i_ready32, 1);
        o_ready = 1'b0;
    endtask

    // ---------------- hand sequence: reset mid-run ----------------
    task automatic reset_mid_test();
        logic [9:0] r8;
        a = 32'h0000_00AA; b = 32'h0000_0055; c_in = 1'b0; i_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        i_valid = 1'b0;
        repeat (3) @(posedge clk);   // bits 0..2 done, bit 3 next
        #2;
        rst = 1'b0;
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        check("midrst_hold_state8", st8, 0);
        check("midrst_hold_ovalid8", o_valid8, 0);
        rst = 1'b1;
        // Operands offered on the very first edge after release.
        run_txn(32'h0000_0001, 32'h0000_0002, 1'b0, 0, r8);
        check("midrst_fresh_res8", r8, {2'b00, 8'h03});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
                 pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence and final report ----------------
    initial begin
        logic [9:0]  r8;
        logic [31:0] ua;
        logic [31:0] ub;

        vecs[0] = '{8'h35, 8'h1A, 1'b0, 8'h4F, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[6] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[7] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};
        vecs[8] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};

        rst = 1'b1; i_valid = 1'b0; o_ready = 1'b0; c_in = 1'b0;
        a = '0; b = '0;
        #1 rst = 1'b0;
        #1;
        check_reset_state("reset");
        repeat (2) @(negedge clk);
        check("reset_held_state8", st8, 0);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            ua = $urandom; ub = $urandom;
            run_txn({ua[31:8], vecs[i].a}, {ub[31:8], vecs[i].b}, vecs[i].ci,
                    (i == 0) ? 0 : 2, r8);
            check($sformatf("tbl%0d_sum", i), r8[7:0], vecs[i].s);
            check($sformatf("tbl%0d_cout", i), r8[8], vecs[i].co);
            check($sformatf("tbl%0d_ovf", i), r8[9], vecs[i].ov);
        end

        bp_test();
        reset_mid_test();

        for (int i = 0; i < 1000; i++) begin
            run_txn($urandom, $urandom, 1'($urandom_range(0, 1)), 3, r8);
        end

        check("queue8_empty", exp8_q.size(), 0);
        check("queue32_empty", exp32_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
